rg_irq_ctrl: RTL and testbench
==============================

// Module: rg_irq_ctrl
// PURPOSE
//  Receiving end of the 20-bit interrupt vector driven by the board buttons/keypad (bit19 Reset,
//  18:13 R/G/B pairs, 12 Pause, 11:0 keypad 1..#). Synchronises the raw lines, detects rising
//  edges, holds them as sticky pending bits, and presents one at a time to the game CPU over a
//  req/ack handshake. Highest bit index has highest priority; a CPU-written mask gates requests.
// PARAMETERS
//  N_SRC        20   number of interrupt lines (irq_id width = 5, fixed; N_SRC <= 32)
//  SYNC_STAGES  2    flip-flop stages in the input synchroniser (>= 2)
//  DEB_CYCLES   16   stable-cycle count for debounce (used only with RG_IRQ_DEBOUNCE_EN)
// PORTS
//  clk          in   1      system clock, all logic on posedge
//  rst_n        in   1      asynchronous active-low reset
//  irq_in       in   N_SRC  raw asynchronous interrupt lines, active-high
//  mask_we      in   1      write strobe for mask register
//  mask_wdata   in   N_SRC  new mask value (1 = source enabled)
//  irq_ack      in   1      CPU acknowledge of current irq_id (single-cycle pulse)
//  irq_req      out  1      request to CPU, level, held until acked
//  irq_id       out  5      index of requested source, stable while irq_req=1
//  pending      out  N_SRC  sticky pending bits (readable status)
//  irq_overrun  out  1      1-cycle pulse: new edge on a source already pending
// BEHAVIOUR
//  Reset (async, rst_n=0): sync chains 0, prev-sample 0, pending 0, mask all-ones, state IDLE,
//   irq_req 0, irq_id 0, irq_overrun 0. Release is synchronous to clk.
//  Input path: irq_in -> SYNC_STAGES flops -> edge = sync & ~prev. A 0->1 input change shows in
//   pending SYNC_STAGES+1 clocks later (3 at default). Levels held high give one edge only.
//  Pending: set on edge; cleared only by ack of that index. Edge and ack-clear of same bit in
//   same cycle -> bit stays set (edge wins). Edge on an already-set bit -> irq_overrun=1.
//  Mask: mask_we loads mask_wdata next clock. Masked bits still pend, never request. Masking
//   the bit currently requested does not retract irq_req.
//  FSM:
//   IDLE : if |(pending & mask): irq_id <= index of highest set bit, go REQ (req next clk).
//   REQ  : irq_req=1, irq_id frozen. On irq_ack: clear pending[irq_id], go GAP.
//   GAP  : irq_req=0 for exactly one cycle, then IDLE (re-arbitrates with updated pending).
//  Latency: pending bit visible -> irq_req high 1 clk; ack -> req low next clk; back-to-back
//   requests separated by >= 2 low cycles (GAP + IDLE arbitration).
//  irq_ack outside REQ is ignored (no state or pending change).
//  irq_id arithmetic: priority encoder over N_SRC bits, zero-extended to 5 bits.
// CONFIGURATION
//  RG_IRQ_DEBOUNCE_EN defined: per-line counter after the synchroniser; the filtered level
//   changes only after the synced input holds a new value DEB_CYCLES consecutive clocks; a
//   glitch shorter than that resets the counter and produces no edge. Adds DEB_CYCLES clks to
//   input latency. Counters reset to 0, filtered level to 0.
//  Undefined: no counters; synced level feeds edge detect directly (latency as above).
// TESTING
//  1 Reset: rst_n=0 mid-REQ -> irq_req=0, pending=0, mask=20'hFFFFF immediately (async).
//  2 irq_in=20'h00800 (key1) for 5 clks -> pending[11]=1 at clk 3, irq_req=1 irq_id=11 at clk 4;
//    ack -> req 0, pending 0.
//  3 irq_in=20'h80001 same clk -> id 19 first; ack; after GAP+IDLE id 0 requested.
//  4 mask_wdata=20'h7FFFF then Reset edge -> pending[19]=1, no req; unmask -> req id 19.
//  5 key2 edge, release, second edge before ack -> irq_overrun pulse, single request id 10.
//  6 RG_IRQ_DEBOUNCE_EN, DEB_CYCLES=16: 5-clk pulse -> no pending; 20-clk pulse -> pending[x]
//    set 16+3 clks after rise.

Source files
------------

// File: rtl/rg_irq_ctrl.sv
// rg_irq_ctrl: sync, edge-detect, sticky-pend and req/ack-serve the 20-bit button/keypad irq vector.
// Ports: clk, rst_n (async low) | irq_in, mask_we, mask_wdata, irq_ack in | irq_req, irq_id, pending, irq_overrun out. Optional RG_IRQ_DEBOUNCE_EN.
module rg_irq_ctrl #(
  parameter int N_SRC       = 20,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  input  logic             irq_ack,
  output logic             irq_req,
  output logic [4:0]       irq_id,
  output logic [N_SRC-1:0] pending,
  output logic             irq_overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [N_SRC-1:0] sync_q [SYNC_STAGES];
  logic [N_SRC-1:0] level;
  logic [N_SRC-1:0] prev_q;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] pend_q;
  logic [N_SRC-1:0] mask_q;
  logic [N_SRC-1:0] ack_clr;
  logic [N_SRC-1:0] req_vec;
  logic [4:0]       id_q;
  logic [4:0]       enc_id;
  logic             ovr_q;
  logic             any_req;
  logic             ack_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++)
        sync_q[s] <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int s = 1; s < SYNC_STAGES; s++)
        sync_q[s] <= sync_q[s-1];
    end
  end

`ifdef RG_IRQ_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [CW-1:0]    cnt_q [N_SRC];
  logic [N_SRC-1:0] filt_q;

  // The counter runs only while the synced line
  // disagrees with the filtered level; any return
  // to agreement restarts it, so short glitches
  // never reach the edge detector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= '0;
      for (int i = 0; i < N_SRC; i++)
        cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (sync_q[SYNC_STAGES-1][i] != filt_q[i]) begin
          if (cnt_q[i] == CW'(DEB_CYCLES - 1)) begin
            filt_q[i] <= sync_q[SYNC_STAGES-1][i];
            cnt_q[i]  <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + CW'(1);
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  assign level = filt_q;
`else
  assign level = sync_q[SYNC_STAGES-1];
`endif

  assign rise    = level & ~prev_q;
  assign ack_hit = (state_q == REQ) && irq_ack;
  assign ack_clr = ack_hit ? (N_SRC'(1) << id_q) : '0;
  assign req_vec = pend_q & mask_q;
  assign any_req = |req_vec;

  // Higher index overwrites lower: highest wins.
  always_comb begin
    enc_id = '0;
    for (int i = 0; i < N_SRC; i++)
      if (req_vec[i])
        enc_id = 5'(i);
  end

  // Edge is OR-ed in after the clear, so a new
  // edge on the bit being acked keeps it pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      pend_q <= '0;
      ovr_q  <= 1'b0;
      mask_q <= '1;
    end else begin
      prev_q <= level;
      pend_q <= (pend_q & ~ack_clr) | rise;
      ovr_q  <= |(rise & pend_q);
      if (mask_we)
        mask_q <= mask_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      state_q == IDLE: if (any_req) state_d = REQ;
      state_q == REQ:  if (irq_ack) state_d = GAP;
      state_q == GAP:  state_d = IDLE;
      default:         state_d = IDLE;
    endcase
  end

  // id is frozen outside the IDLE arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      id_q <= '0;
    else if (state_q == IDLE && any_req)
      id_q <= enc_id;
  end

  always_comb begin
    irq_req = 1'b0;
    unique case (1'b1)
      state_q == REQ: irq_req = 1'b1;
      default:        irq_req = 1'b0;
    endcase
  end

  assign irq_id      = id_q;
  assign pending     = pend_q;
  assign irq_overrun = ovr_q;

endmodule

// File: tb/tb_rg_irq_ctrl.sv
// tb_rg_irq_ctrl: directed bench, expected ids queued by stimulus,
// popped by a monitor on each irq_req rise; status checked inline.
module tb_rg_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] irq_in;
  logic        mask_we;
  logic [19:0] mask_wdata;
  logic        irq_ack;
  logic        irq_req;
  logic [4:0]  irq_id;
  logic [19:0] pending;
  logic        irq_overrun;

  int total = 0;
  int bad   = 0;

  logic [4:0] exp_q [$];
  logic       req_seen = 1'b0;
  logic [4:0] held_id  = '0;

  rg_irq_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .irq_ack    (irq_ack),
    .irq_req    (irq_req),
    .irq_id     (irq_id),
    .pending    (pending),
    .irq_overrun(irq_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
  endtask

  // Monitor: each new request must match the
  // next queued id; id must hold while req=1.
  always @(negedge clk) begin
    if (irq_req && !req_seen) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_req", {27'd0, irq_id}, 32'hFF);
      end else begin
        chk("req_id", {27'd0, irq_id},
            {27'd0, exp_q.pop_front()});
      end
      held_id = irq_id;
    end else if (irq_req && req_seen) begin
      chk("id_stable", {27'd0, irq_id},
          {27'd0, held_id});
    end
    req_seen = irq_req;
  end

  initial begin
    rst_n      = 1'b0;
    irq_in     = '0;
    mask_we    = 1'b0;
    mask_wdata = '0;
    irq_ack    = 1'b0;
    tick(2);
    chk("rst_req", {31'd0, irq_req}, 0);
    chk("rst_id", {27'd0, irq_id}, 0);
    chk("rst_pend", {12'd0, pending}, 0);
    chk("rst_ovr", {31'd0, irq_overrun}, 0);
    rst_n = 1'b1;
    tick(2);

    // key1 (bit 11): pend at +3, req at +4
    exp_q.push_back(5'd11);
    irq_in = 20'h00800;
    tick(3);
    chk("k1_pend", {12'd0, pending}, 32'h00800);
    chk("k1_noreq", {31'd0, irq_req}, 0);
    tick(1);
    chk("k1_req", {31'd0, irq_req}, 1);
    tick(1);
    irq_in = '0;
    ack();
    chk("k1_ackreq", {31'd0, irq_req}, 0);
    chk("k1_ackpend", {12'd0, pending}, 0);
    tick(4);

    // Reset + key0 together: 19 first, then 0
    exp_q.push_back(5'd19);
    exp_q.push_back(5'd0);
    irq_in = 20'h80001;
    tick(4);
    chk("pr_req19", {31'd0, irq_req}, 1);
    chk("pr_pend", {12'd0, pending}, 32'h80001);
    ack();
    chk("pr_gap", {31'd0, irq_req}, 0);
    tick(1);
    chk("pr_idle", {31'd0, irq_req}, 0);
    tick(1);
    chk("pr_req0", {31'd0, irq_req}, 1);
    irq_in = '0;
    ack();
    chk("pr_pend0", {12'd0, pending}, 0);
    tick(4);

    // Masked Reset pends but never requests
    mask_we    = 1'b1;
    mask_wdata = 20'h7FFFF;
    tick(1);
    mask_we = 1'b0;
    irq_in  = 20'h80000;
    tick(3);
    chk("mk_pend", {12'd0, pending}, 32'h80000);
    tick(3);
    chk("mk_noreq", {31'd0, irq_req}, 0);
    ack();
    chk("mk_ackidle", {12'd0, pending}, 32'h80000);
    exp_q.push_back(5'd19);
    mask_we    = 1'b1;
    mask_wdata = 20'hFFFFF;
    tick(1);
    mask_we = 1'b0;
    chk("mk_arb", {31'd0, irq_req}, 0);
    tick(1);
    chk("mk_req", {31'd0, irq_req}, 1);
    irq_in = '0;
    ack();
    chk("mk_clr", {12'd0, pending}, 0);
    tick(4);

    // key2 (bit 10) re-edges while pending
    exp_q.push_back(5'd10);
    irq_in = 20'h00400;
    tick(2);
    irq_in = '0;
    tick(2);
    irq_in = 20'h00400;
    tick(2);
    chk("ov_before", {31'd0, irq_overrun}, 0);
    chk("ov_req", {31'd0, irq_req}, 1);
    tick(1);
    chk("ov_pulse", {31'd0, irq_overrun}, 1);
    tick(1);
    chk("ov_after", {31'd0, irq_overrun}, 0);
    ack();
    chk("ov_clr", {12'd0, pending}, 0);
    tick(3);
    chk("ov_single", {31'd0, irq_req}, 0);
    irq_in = '0;
    tick(4);

    // Pause (bit 12): mask off mid-REQ, then
    // async reset mid-cycle
    exp_q.push_back(5'd12);
    irq_in = 20'h01000;
    tick(4);
    chk("rs_req", {31'd0, irq_req}, 1);
    mask_we    = 1'b1;
    mask_wdata = 20'h00000;
    tick(1);
    mask_we = 1'b0;
    chk("rs_keep", {31'd0, irq_req}, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rs_req0", {31'd0, irq_req}, 0);
    chk("rs_pend0", {12'd0, pending}, 0);
    chk("rs_id0", {27'd0, irq_id}, 0);
    tick(1);
    rst_n = 1'b1;
    // held line re-edges; mask must be all-ones
    exp_q.push_back(5'd12);
    tick(3);
    chk("rs_repend", {12'd0, pending}, 32'h01000);
    tick(1);
    chk("rs_rereq", {31'd0, irq_req}, 1);
    irq_in = '0;
    ack();
    tick(4);

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
